// File: rtl/intersection_pkg.sv
// Shared light encoding, FSM state type and counter sizing for the intersection controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package intersection_pkg;

   localparam logic [1:0] LIGHT_RED    = 2'd0;
   localparam logic [1:0] LIGHT_GREEN  = 2'd1;
   localparam logic [1:0] LIGHT_YELLOW = 2'd2;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_NS_G = 3'd1,
      ST_NS_Y = 3'd2,
      ST_AR1  = 3'd3,
      ST_EW_G = 3'd4,
      ST_EW_Y = 3'd5,
      ST_AR2  = 3'd6,
      ST_WALK = 3'd7
   } state_t;

   // Width needed to hold the largest phase length (the counter holds TIME-1 at most).
   function automatic int cnt_width(input int g, input int y, input int a, input int w);
      int m;
      m = g;
      if (y > m) m = y;
      if (a > m) m = a;
      if (w > m) m = w;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/intersection_ctrl_phase_timer.sv
// Loadable down-counter timing one intersection phase; done flags a zero count.
// Latency: load takes effect on the next edge; done is combinational from the count register.
// Backpressure: none; counter saturates at zero until reloaded.
module phase_timer #(
   parameter int W = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic         done
);

   logic [W-1:0] cnt;

   // Load on phase entry, otherwise count down and hold at zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (cnt != '0) begin
         cnt <= cnt - W'(1);
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/intersection_ctrl.sv
// Two-road intersection sequencer with an on-request pedestrian WALK phase.
// Latency: all outputs registered; phase changes appear the cycle after the deciding edge.
// Backpressure: none; enable low aborts to IDLE on the next edge.
module intersection_ctrl
   import intersection_pkg::*;
#(
   parameter int GREEN_TIME  = 4,
   parameter int YELLOW_TIME = 2,
   parameter int ALLRED_TIME = 1,
   parameter int WALK_TIME   = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable,
   input  logic       ped_req,
   output logic [1:0] ns_state,
   output logic [1:0] ew_state,
   output logic       walk,
   output logic       ped_pending
);

   localparam int CW = cnt_width(GREEN_TIME, YELLOW_TIME, ALLRED_TIME, WALK_TIME);
   localparam logic [CW-1:0] G_LD = CW'(GREEN_TIME - 1);
   localparam logic [CW-1:0] Y_LD = CW'(YELLOW_TIME - 1);
   localparam logic [CW-1:0] A_LD = CW'(ALLRED_TIME - 1);
   localparam logic [CW-1:0] W_LD = CW'(WALK_TIME - 1);

   state_t        state, state_nx;
   logic          next_dir, next_dir_nx;
   logic          ped_pending_nx;
   logic [1:0]    ns_nx, ew_nx;
   logic          walk_nx;
   logic          load;
   logic [CW-1:0] load_val;
   logic          done;
   logic          ped_hit;

   phase_timer #(.W(CW)) u_timer (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .load_val (load_val),
      .done     (done)
   );

   // A request in the final all-red cycle is served without waiting for the latch.
   assign ped_hit = ped_pending | ped_req;

   // Next phase, timer reload, pending-request latch and output decode of the next phase.
   always_comb begin
      state_nx       = state;
      next_dir_nx    = next_dir;
      load           = 1'b0;
      load_val       = '0;
      ped_pending_nx = ped_pending;
      ns_nx          = LIGHT_RED;
      ew_nx          = LIGHT_RED;
      walk_nx        = 1'b0;

      if (!enable) begin
         state_nx = ST_IDLE;
         load     = 1'b1;
         load_val = '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state_nx = ST_NS_G;
               load     = 1'b1;
               load_val = G_LD;
            end
            ST_NS_G: if (done) begin
               state_nx = ST_NS_Y; load = 1'b1; load_val = Y_LD;
            end
            ST_NS_Y: if (done) begin
               state_nx = ST_AR1; load = 1'b1; load_val = A_LD;
            end
            ST_AR1: if (done) begin
               load = 1'b1;
               if (ped_hit) begin
                  state_nx = ST_WALK; load_val = W_LD; next_dir_nx = 1'b1;
               end else begin
                  state_nx = ST_EW_G; load_val = G_LD;
               end
            end
            ST_EW_G: if (done) begin
               state_nx = ST_EW_Y; load = 1'b1; load_val = Y_LD;
            end
            ST_EW_Y: if (done) begin
               state_nx = ST_AR2; load = 1'b1; load_val = A_LD;
            end
            ST_AR2: if (done) begin
               load = 1'b1;
               if (ped_hit) begin
                  state_nx = ST_WALK; load_val = W_LD; next_dir_nx = 1'b0;
               end else begin
                  state_nx = ST_NS_G; load_val = G_LD;
               end
            end
            ST_WALK: if (done) begin
               state_nx = next_dir ? ST_EW_G : ST_NS_G;
               load     = 1'b1;
               load_val = G_LD;
            end
            default: begin
               state_nx = ST_IDLE;
               load     = 1'b1;
            end
         endcase
      end

      // Clear on entry to WALK wins over a same-cycle request; requests during WALK are dropped.
      if (!enable)
         ped_pending_nx = 1'b0;
      else if (state_nx == ST_WALK && state != ST_WALK)
         ped_pending_nx = 1'b0;
      else if (ped_req && state != ST_WALK)
         ped_pending_nx = 1'b1;

      case (state_nx)
         ST_NS_G: ns_nx = LIGHT_GREEN;
         ST_NS_Y: ns_nx = LIGHT_YELLOW;
         ST_EW_G: ew_nx = LIGHT_GREEN;
         ST_EW_Y: ew_nx = LIGHT_YELLOW;
         ST_WALK: walk_nx = 1'b1;
         default: ;
      endcase
   end

   // State, direction memory and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         next_dir    <= 1'b0;
         ped_pending <= 1'b0;
         ns_state    <= LIGHT_RED;
         ew_state    <= LIGHT_RED;
         walk        <= 1'b0;
      end else begin
         state       <= state_nx;
         next_dir    <= next_dir_nx;
         ped_pending <= ped_pending_nx;
         ns_state    <= ns_nx;
         ew_state    <= ew_nx;
         walk        <= walk_nx;
      end
   end

endmodule

// File: tb/tb_intersection_ctrl.sv
// Scoreboard bench for the intersection sequencer: expected light/walk/pending per cycle.
// Latency: compares each cycle 1 time unit after the rising edge.
// Backpressure: n/a.
module tb_intersection_ctrl;

   localparam logic [1:0] R = 2'd0;
   localparam logic [1:0] G = 2'd1;
   localparam logic [1:0] Y = 2'd2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       enable = 1'b0;
   logic       ped_req = 1'b0;
   logic [1:0] ns_state, ew_state;
   logic       walk, ped_pending;

   int checks = 0;
   int failures = 0;
   logic mon_on = 1'b0;
   logic [5:0] exp_q[$];

   intersection_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .ped_req     (ped_req),
      .ns_state    (ns_state),
      .ew_state    (ew_state),
      .walk        (walk),
      .ped_pending (ped_pending)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at t=%0t: got=%h expected=%h", tag, $time, got, exp);
      end
   endtask

   // Expected word is {ns, ew, walk, ped_pending}.
   task automatic push_exp(input logic [1:0] ns, input logic [1:0] ew,
                           input logic w, input logic p, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back({ns, ew, w, p});
   endtask

   task automatic drive(input logic en, input logic req, input int n);
      enable  = en;
      ped_req = req;
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Scoreboard: one expected entry consumed per clock while monitoring.
   always @(posedge clk) begin
      if (mon_on) begin
         #1;
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            logic [5:0] e;
            e = exp_q.pop_front();
            check("sb_ns_ew_walk_pend", 32'({ns_state, ew_state, walk, ped_pending}), 32'(e));
         end
      end
   end

   // Safety invariant on every cycle out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         check("safety_roads", 32'(ns_state != R && ew_state != R), 32'd0);
         check("safety_walk", 32'(walk && (ns_state != R || ew_state != R)), 32'd0);
      end
   end

   initial begin
      #12;
      check("rst_ns", 32'(ns_state), 32'(R));
      check("rst_ew", 32'(ew_state), 32'(R));
      check("rst_walk", 32'(walk), 32'd0);
      check("rst_pend", 32'(ped_pending), 32'd0);
      @(posedge clk);
      #2;
      rst_n  = 1'b1;
      mon_on = 1'b1;

      // Free-running cycle, no pedestrians: 3 periods of 14.
      for (int p = 0; p < 3; p++) begin
         push_exp(G, R, 0, 0, 4); push_exp(Y, R, 0, 0, 2); push_exp(R, R, 0, 0, 1);
         push_exp(R, G, 0, 0, 4); push_exp(R, Y, 0, 0, 2); push_exp(R, R, 0, 0, 1);
      end
      drive(1, 0, 42);

      // Pulse during the 2nd NS green; WALK after AR1 then EW green.
      push_exp(G, R, 0, 0, 2); push_exp(G, R, 0, 1, 2); push_exp(Y, R, 0, 1, 2);
      push_exp(R, R, 0, 1, 1); push_exp(R, R, 1, 0, 3); push_exp(R, G, 0, 0, 4);
      push_exp(R, Y, 0, 0, 2); push_exp(R, R, 0, 0, 1);
      drive(1, 0, 2);
      drive(1, 1, 1);
      drive(1, 0, 14);

      // Request held high: WALK after every all-red, never back to back.
      push_exp(R, R, 1, 0, 3); push_exp(G, R, 0, 0, 1); push_exp(G, R, 0, 1, 3);
      push_exp(Y, R, 0, 1, 2); push_exp(R, R, 0, 1, 1); push_exp(R, R, 1, 0, 3);
      push_exp(R, G, 0, 0, 1); push_exp(R, G, 0, 1, 3); push_exp(R, Y, 0, 1, 2);
      push_exp(R, R, 0, 1, 1); push_exp(R, R, 1, 0, 3);
      drive(1, 1, 23);

      // Plain cycle back to AR2, then a request only in the AR2 cycle.
      push_exp(G, R, 0, 0, 4); push_exp(Y, R, 0, 0, 2); push_exp(R, R, 0, 0, 1);
      push_exp(R, G, 0, 0, 4); push_exp(R, Y, 0, 0, 2); push_exp(R, R, 0, 0, 1);
      drive(1, 0, 14);
      push_exp(R, R, 1, 0, 3); push_exp(G, R, 0, 0, 1);
      drive(1, 1, 1);
      drive(1, 0, 3);

      // Abort in the 3rd EW green with a request pending; idle ignores requests.
      push_exp(G, R, 0, 0, 3); push_exp(Y, R, 0, 0, 2); push_exp(R, R, 0, 0, 1);
      push_exp(R, G, 0, 0, 1); push_exp(R, G, 0, 1, 2); push_exp(R, R, 0, 0, 2);
      push_exp(G, R, 0, 0, 4);
      drive(1, 0, 7);
      drive(1, 1, 1);
      drive(1, 0, 1);
      drive(0, 0, 1);
      drive(0, 1, 1);
      drive(1, 0, 4);

      // Reach mid-WALK, then asynchronous reset.
      push_exp(Y, R, 0, 1, 2); push_exp(R, R, 0, 1, 1); push_exp(R, R, 1, 0, 2);
      drive(1, 1, 1);
      drive(1, 0, 4);
      mon_on = 1'b0;
      rst_n  = 1'b0;
      #1;
      check("arst_ns", 32'(ns_state), 32'(R));
      check("arst_ew", 32'(ew_state), 32'(R));
      check("arst_walk", 32'(walk), 32'd0);
      check("arst_pend", 32'(ped_pending), 32'd0);
      #1;
      rst_n  = 1'b1;
      mon_on = 1'b1;
      push_exp(G, R, 0, 0, 2);
      drive(1, 0, 2);

      mon_on = 1'b0;
      check("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
